yarvi_reg_scoreboard: RTL and testbench

Register scoreboard for the YARVI decode stage. It decodes source and destination register usage of one RV32I instruction per cycle and tracks outstanding register writes with a per-register counter. It holds decode (`stall`) on RAW and counter-overflow hazards and retires writes reported by up to `WB_PORTS` write-back ports. It sits between fetch/decode and the execute/issue logic and replaces the purely combinational usage decode with a stateful hazard check.

---
 rtl/yarvi_reg_scoreboard_pkg.sv | 25 ++
 rtl/yarvi_dec_reg_usage3.sv | 51 +++++
 rtl/yarvi_reg_scoreboard.sv | 101 ++++++++++
 tb/tb_yarvi_reg_scoreboard.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/yarvi_reg_scoreboard_pkg.sv
// Shared RV32I decode constants for the register scoreboard.
// Opcodes, funct3 values and instruction field positions.
package yarvi_reg_scoreboard_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;

  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

endpackage

// File: rtl/yarvi_dec_reg_usage3.sv
// Combinational register-usage decode of one RV32I instruction.
// Ports: valid/insn in; use_rs1/use_rs2/use_rd out. All flags are 0
// when !valid or when the corresponding register field is x0.
module yarvi_dec_reg_usage3
  import yarvi_reg_scoreboard_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] insn,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        use_rd
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic       r1, r2, wd;
  logic       unused_hi;

  assign opc = insn[6:0];
  assign f3  = insn[F3_LSB +: 3];
  assign rd  = insn[RD_LSB +: 5];
  assign rs1 = insn[RS1_LSB +: 5];
  assign rs2 = insn[RS2_LSB +: 5];
  assign unused_hi = ^insn[31:25];

  always_comb begin
    r1 = 1'b0;
    r2 = 1'b0;
    wd = 1'b0;
    case (opc)
      OPC_BRANCH, OPC_STORE: begin r1 = 1'b1; r2 = 1'b1; end
      OPC_OP:                begin r1 = 1'b1; r2 = 1'b1; wd = 1'b1; end
      OPC_OP_IMM, OPC_LOAD,
      OPC_JALR:              begin r1 = 1'b1; wd = 1'b1; end
      OPC_LUI, OPC_AUIPC,
      OPC_JAL:               wd = 1'b1;
      OPC_SYSTEM: begin
        // immediate CSR forms reuse the rs1 field as a zimm, not a register
        r1 = (f3 == F3_CSRRW) || (f3 == F3_CSRRS) || (f3 == F3_CSRRC);
        wd = (f3 != 3'b000);
      end
      default: ;
    endcase
  end

  assign use_rs1 = valid & r1 & (rs1 != 5'd0);
  assign use_rs2 = valid & r2 & (rs2 != 5'd0);
  assign use_rd  = valid & wd & (rd  != 5'd0);

endmodule

// File: rtl/yarvi_reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters for x1..x31.
// Ports: clock/reset (sync, active high); dec_valid/dec_insn decode
// input; flush; wb_valid/wb_rd write-back ports (port i at [5i+4:5i]).
// Outputs: use_rs1/use_rs2/use_rd, stall, issue (combinational),
// busy and sticky wb_err (registered).
module yarvi_reg_scoreboard
  import yarvi_reg_scoreboard_pkg::*;
#(
  parameter int WB_PORTS = 2,
  parameter int CNT_W    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [31:0]           dec_insn,
  input  logic                  flush,
  input  logic [WB_PORTS-1:0]   wb_valid,
  input  logic [5*WB_PORTS-1:0] wb_rd,
  output logic                  use_rs1,
  output logic                  use_rs2,
  output logic                  use_rd,
  output logic                  stall,
  output logic                  issue,
  output logic                  busy,
  output logic                  wb_err
);

  localparam int DW = $clog2(WB_PORTS + 1);
  localparam int SW = ((CNT_W > DW) ? CNT_W : DW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // index 0 is held at zero so x0 lookups read as "nothing pending"
  logic [31:0][CNT_W-1:0]    cnt_q;
  logic [31:1][CNT_W-1:0]    cnt_d;
  logic [31:1][DW-1:0]       dec_n;
  logic [WB_PORTS-1:0][31:1] wb_hit;
  logic [31:1]               inc_v, err_v;
  logic [4:0]                rd_f, rs1_f, rs2_f;

  assign rd_f  = dec_insn[RD_LSB +: 5];
  assign rs1_f = dec_insn[RS1_LSB +: 5];
  assign rs2_f = dec_insn[RS2_LSB +: 5];

  yarvi_dec_reg_usage3 u_usage (
    .valid   (dec_valid),
    .insn    (dec_insn),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .use_rd  (use_rd)
  );

  // hazards look only at registered counts; same-cycle write-backs don't release
  assign stall = dec_valid & ((use_rs1 & (cnt_q[rs1_f] != '0)) |
                              (use_rs2 & (cnt_q[rs2_f] != '0)) |
                              (use_rd  & (cnt_q[rd_f]  == CNT_MAX)));
  assign issue = dec_valid & ~stall & ~flush;

  // one-hot hit per port; the >>1 drops x0 so write-backs to it are ignored
  for (genvar i = 0; i < WB_PORTS; i++) begin : g_wb
    assign wb_hit[i] = wb_valid[i] ? 31'((32'd1 << wb_rd[5*i +: 5]) >> 1) : '0;
  end

  always_comb begin
    dec_n = '0;
    inc_v = '0;
    for (int r = 1; r < 32; r++) begin
      inc_v[r] = issue & use_rd & (rd_f == 5'(r));
      for (int i = 0; i < WB_PORTS; i++)
        dec_n[r] = dec_n[r] + DW'(wb_hit[i][r]);
    end
  end

  // decrements beyond what is pending are dropped and flagged
  always_comb begin
    cnt_d = '0;
    err_v = '0;
    for (int r = 1; r < 32; r++) begin
      if (SW'(dec_n[r]) > SW'(cnt_q[r]) + SW'(inc_v[r]))
        err_v[r] = 1'b1;
      else
        cnt_d[r] = CNT_W'(SW'(cnt_q[r]) + SW'(inc_v[r]) - SW'(dec_n[r]));
    end
    if (flush) begin
      cnt_d = '0;
      err_v = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      busy   <= 1'b0;
      wb_err <= 1'b0;
    end else begin
      cnt_q  <= {cnt_d, {CNT_W{1'b0}}};
      busy   <= |cnt_d;
      wb_err <= wb_err | (|err_v);
    end
  end

endmodule

// File: tb/tb_yarvi_reg_scoreboard.sv
module tb_yarvi_reg_scoreboard;

  localparam int MAXC = 3;

  logic        clock = 1'b0;
  logic        reset, dec_valid, flush;
  logic [31:0] dec_insn;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic        use_rs1, use_rs2, use_rd, stall, issue, busy, wb_err;

  always #5 clock = ~clock;

  yarvi_reg_scoreboard #(.WB_PORTS(2), .CNT_W(2)) dut (
    .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_insn(dec_insn),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .use_rd(use_rd),
    .stall(stall), .issue(issue), .busy(busy), .wb_err(wb_err)
  );

  typedef struct packed {
    logic u1, u2, ud, st, is, bz, er;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   m_cnt[32];
  bit   m_err = 0, m_busy = 0, m_st = 0;
  bit   done = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // reference decode straight from the RV32I usage rules
  function automatic void model_use(input logic [31:0] in, input bit v,
                                    output bit u1, output bit u2, output bit ud);
    logic [6:0] op = in[6:0];
    logic [2:0] f3 = in[14:12];
    u1 = 0; u2 = 0; ud = 0;
    case (op)
      7'b1100011, 7'b0110011, 7'b0100011: begin u1 = 1; u2 = 1; end
      7'b0010011, 7'b0000011, 7'b1100111: u1 = 1;
      7'b1110011: u1 = (f3 >= 3'd1 && f3 <= 3'd3);
      default: ;
    endcase
    ud = (op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111 ||
          op == 7'b1100111 || op == 7'b0110011 || op == 7'b0010011 ||
          op == 7'b0000011 || (op == 7'b1110011 && f3 != 3'd0));
    if (in[19:15] == 0) u1 = 0;
    if (in[24:20] == 0) u2 = 0;
    if (in[11:7]  == 0) ud = 0;
    if (!v) begin u1 = 0; u2 = 0; ud = 0; end
  endfunction

  task automatic step(input bit rst, input bit v, input logic [31:0] in, input bit fl,
                      input logic [1:0] wv, input logic [9:0] wrd, input bit do_chk);
    bit u1, u2, ud, st, is;
    exp_t e;
    @(negedge clock);
    reset = rst; dec_valid = v; dec_insn = in; flush = fl; wb_valid = wv; wb_rd = wrd;
    model_use(in, v, u1, u2, ud);
    st = v && ((u1 && m_cnt[in[19:15]] > 0) || (u2 && m_cnt[in[24:20]] > 0) ||
               (ud && m_cnt[in[11:7]] == MAXC));
    is = v && !st && !fl;
    m_st = st;
    e = '{u1: u1, u2: u2, ud: ud, st: st, is: is, bz: m_busy, er: m_err};
    if (do_chk) q.push_back(e);
    if (rst) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_err = 0;
    end else if (fl) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
    end else begin
      if (is && ud) m_cnt[in[11:7]]++;
      for (int p = 0; p < 2; p++) begin
        int r = int'(wrd[5*p +: 5]);
        if (wv[p] && r != 0) begin
          if (m_cnt[r] > 0) m_cnt[r]--;
          else m_err = 1;
        end
      end
    end
    m_busy = 0;
    foreach (m_cnt[r]) if (m_cnt[r] != 0) m_busy = 1;
  endtask

  // monitor: compares every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("use_rs1", use_rs1, e.u1);
        chk("use_rs2", use_rs2, e.u2);
        chk("use_rd",  use_rd,  e.ud);
        chk("stall",   stall,   e.st);
        chk("issue",   issue,   e.is);
        chk("busy",    busy,    e.bz);
        chk("wb_err",  wb_err,  e.er);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [2:0] f3, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, rd, op};
  endfunction

  initial begin
    logic [6:0]  ops[11];
    logic [31:0] cur, ld5, add6, addi7, addi3, csrwi;
    bit          v;
    ops = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011, 7'b0110111,
            7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011, 7'b1111111};
    foreach (m_cnt[r]) m_cnt[r] = 0;
    cur = 32'h0; v = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);

    // randomized traffic; write-backs only target model-pending registers
    for (int c = 0; c < 3000; c++) begin
      int av[32];
      bit fl;
      logic [1:0] wv;
      logic [9:0] wrd;
      if (!(v && m_st)) begin
        cur = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               3'($urandom), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 10)]};
        v = ($urandom % 4) != 0;
      end
      av = m_cnt;
      wv = '0;
      wrd = 10'($urandom);
      for (int p = 0; p < 2; p++) begin
        if ($urandom % 3 == 0) begin
          int cand[$];
          for (int r = 1; r < 32; r++) if (av[r] > 0) cand.push_back(r);
          if (cand.size() > 0) begin
            int r = cand[$urandom_range(0, cand.size() - 1)];
            av[r]--;
            wv[p] = 1;
            wrd[5*p +: 5] = 5'(r);
          end else if ($urandom % 2 == 0) begin
            wv[p] = 1;
            wrd[5*p +: 5] = 5'd0;
          end
        end
      end
      fl = ($urandom % 40) == 0;
      step(0, v, cur, fl, wv, wrd, 1);
    end

    step(1, 0, 0, 0, 0, 0, 1);

    // RAW stall released one cycle after the write-back registers
    ld5  = mk(7'b0000011, 5'd5, 3'b010, 5'd1, 5'd0);
    add6 = mk(7'b0110011, 5'd6, 3'b000, 5'd5, 5'd1);
    step(0, 1, ld5, 0, 0, 0, 1);  #3 chk("raw_ld_issue", issue, 1'b1);
    step(0, 1, add6, 0, 0, 0, 1); #3 chk("raw_stall", stall, 1'b1);
                                     chk("raw_busy1", busy, 1'b1);
    step(0, 1, add6, 0, 2'b01, 10'd5, 1); #3 chk("raw_stall_wbcyc", stall, 1'b1);
    step(0, 1, add6, 0, 0, 0, 1); #3 chk("raw_issue", issue, 1'b1);
    step(0, 0, 0, 0, 2'b01, 10'd6, 1);
    step(0, 0, 0, 0, 0, 0, 1);    #3 chk("raw_busy0", busy, 1'b0);

    // x0 destination and x0 write-back
    step(0, 1, {12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011}, 0, 2'b01, 10'd0, 1);
    #3 chk("x0_use_rd", use_rd, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1);    #3 chk("x0_no_err", wb_err, 1'b0);
                                     chk("x0_no_busy", busy, 1'b0);

    // saturation then dual write-back to the same register
    addi7 = mk(7'b0010011, 5'd7, 3'b000, 5'd0, 5'd0);
    repeat (3) step(0, 1, addi7, 0, 0, 0, 1);
    step(0, 1, addi7, 0, 0, 0, 1); #3 chk("sat_stall", stall, 1'b1);
    step(0, 1, addi7, 0, 2'b11, {5'd7, 5'd7}, 1); #3 chk("sat_stall_wbcyc", stall, 1'b1);
    step(0, 1, addi7, 0, 0, 0, 1); #3 chk("sat_issue", issue, 1'b1);
    step(0, 0, 0, 0, 2'b11, {5'd7, 5'd7}, 1);
    step(0, 0, 0, 0, 0, 0, 1);    #3 chk("sat_drained", busy, 1'b0);
                                     chk("sat_no_err", wb_err, 1'b0);

    // flush wins over issue and write-back
    addi3 = mk(7'b0010011, 5'd3, 3'b000, 5'd0, 5'd0);
    step(0, 1, addi3, 0, 0, 0, 1);
    step(0, 1, addi3, 1, 2'b01, 10'd3, 1); #3 chk("flush_issue", issue, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1);    #3 chk("flush_busy", busy, 1'b0);
                                     chk("flush_err", wb_err, 1'b0);

    // immediate CSR form ignores a pending register in the rs1 field
    csrwi = {12'h300, 5'd5, 3'b101, 5'd4, 7'b1110011};
    step(0, 1, ld5, 0, 0, 0, 1);
    step(0, 1, csrwi, 0, 0, 0, 1); #3 chk("csri_use_rs1", use_rs1, 1'b0);
                                      chk("csri_stall", stall, 1'b0);
                                      chk("csri_issue", issue, 1'b1);
    step(0, 0, 0, 0, 2'b11, {5'd4, 5'd5}, 1);
    step(0, 0, 0, 0, 0, 0, 1);    #3 chk("csri_drained", busy, 1'b0);

    // spurious write-back sets the sticky error
    step(0, 0, 0, 0, 2'b10, {5'd9, 5'd0}, 1);
    step(0, 0, 0, 0, 0, 0, 1);    #3 chk("spur_err", wb_err, 1'b1);
                                     chk("spur_busy", busy, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1);    #3 chk("spur_sticky", wb_err, 1'b1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);    #3 chk("rst_err_clr", wb_err, 1'b0);

    @(negedge clock);
    #4;
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
